multi_alarm_ctrl: RTL and testbench

- Parametrised successor to the single-alarm logic inside DigitalClock.
- Holds NUM_ALARMS independently programmable alarms. Each alarm supports snooze and ring timeout.
- Also produces the hourly chime and drives the gated tone on beep.
- Sits between the time counter (which supplies the time and a 1 Hz tick), the debounced key logic, and the buzzer pin.

---
 rtl/clock_pkg.sv | 21 ++
 rtl/multi_alarm_ctrl_if.sv | 15 +
 rtl/alarm_channel.sv | 100 ++++++++++
 rtl/multi_alarm_ctrl.sv | 149 ++++++++++++++
 tb/tb_multi_alarm_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared widths, constants and the per-alarm state encoding for the alarm block.
// The helper gives the register width needed to hold the values 0..max_val.
package clock_pkg;

    localparam int HOUR_W       = 5;
    localparam int MIN_W        = 6;
    localparam int SEC_W        = 6;
    localparam int SECS_PER_MIN = 60;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZED = 2'd3
    } alarm_state_e;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/multi_alarm_ctrl_if.sv
// Alarm programming bus: one-cycle write strobe plus the target index, time and arm bit.
interface multi_alarm_ctrl_if
    import clock_pkg::*;
#(
    parameter int IDX_W = 2
);
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [HOUR_W-1:0] wr_hour;
    logic [MIN_W-1:0]  wr_min;
    logic              wr_enable;

    modport master (output wr_en, wr_idx, wr_hour, wr_min, wr_enable);
    modport slave  (input  wr_en, wr_idx, wr_hour, wr_min, wr_enable);
endinterface

// File: rtl/alarm_channel.sv
// One alarm: programmed time, arm bit, IDLE/PENDING/RINGING/SNOOZED FSM and snooze countdown.
// Ring timing and arbitration live in the parent; this channel only reacts to grant/off/snooze/timeout.
module alarm_channel
    import clock_pkg::*;
#(
    parameter int SNOOZE_MIN = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sec_tick,
    input  logic              time_valid,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [SEC_W-1:0]  cur_sec,
    input  logic              wr_sel,
    input  logic [HOUR_W-1:0] wr_hour,
    input  logic [MIN_W-1:0]  wr_min,
    input  logic              wr_enable,
    input  logic              grant,
    input  logic              key_off,
    input  logic              key_snooze,
    input  logic              timeout,
    output logic              trigger,
    output logic              is_pending,
    output logic              is_ringing
);

    localparam int SNOOZE_S = SNOOZE_MIN * SECS_PER_MIN;
    localparam int SNZ_W    = cnt_width(SNOOZE_S);
    localparam logic [SNZ_W-1:0] SNOOZE_LOAD = SNZ_W'(SNOOZE_S);

    logic [HOUR_W-1:0] hour_reg, hour_next;
    logic [MIN_W-1:0]  min_reg, min_next;
    logic              armed_reg, armed_next;
    alarm_state_e      state_reg, state_next;
    logic [SNZ_W-1:0]  snooze_reg, snooze_next;

    // Only an idle alarm can fire, so a snoozed or ringing one is never re-queued by the match.
    assign trigger = sec_tick & time_valid & armed_reg & (state_reg == ST_IDLE) &
                     (cur_hour == hour_reg) & (cur_min == min_reg) & (cur_sec == '0);

    assign is_pending = (state_reg == ST_PENDING);
    assign is_ringing = (state_reg == ST_RINGING);

    always_comb begin
        hour_next   = hour_reg;
        min_next    = min_reg;
        armed_next  = armed_reg;
        state_next  = state_reg;
        snooze_next = snooze_reg;
        if (wr_sel) begin
            hour_next   = wr_hour;
            min_next    = wr_min;
            armed_next  = wr_enable;
            state_next  = ST_IDLE;
            snooze_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE:    if (trigger) state_next = ST_PENDING;
                ST_PENDING: if (grant) state_next = ST_RINGING;
                ST_RINGING: begin
                    if (key_off || timeout) begin
                        state_next = ST_IDLE;
                    end else if (key_snooze) begin
                        state_next  = ST_SNOOZED;
                        snooze_next = SNOOZE_LOAD;
                    end
                end
                ST_SNOOZED: begin
                    if (sec_tick) begin
                        if (snooze_reg <= SNZ_W'(1)) begin
                            state_next  = ST_PENDING;
                            snooze_next = '0;
                        end else begin
                            snooze_next = snooze_reg - SNZ_W'(1);
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hour_reg   <= '0;
            min_reg    <= '0;
            armed_reg  <= 1'b0;
            state_reg  <= ST_IDLE;
            snooze_reg <= '0;
        end else begin
            hour_reg   <= hour_next;
            min_reg    <= min_next;
            armed_reg  <= armed_next;
            state_reg  <= state_next;
            snooze_reg <= snooze_next;
        end
    end

endmodule

// File: rtl/multi_alarm_ctrl.sv
// Multi-alarm controller: NUM_ALARMS channels, lowest-index-first ring arbiter,
// ring timeout, hourly chime and the gated square-wave tone for the buzzer.
module multi_alarm_ctrl
    import clock_pkg::*;
#(
    parameter  int NUM_ALARMS     = 4,
    parameter  int SNOOZE_MIN     = 5,
    parameter  int RING_TIMEOUT_S = 60,
    parameter  int CHIME_S        = 1,
    parameter  int TONE_DIV       = 12500,
    localparam int IDX_W          = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sec_tick,
    input  logic [HOUR_W-1:0]     cur_hour,
    input  logic [MIN_W-1:0]      cur_min,
    input  logic [SEC_W-1:0]      cur_sec,
    input  logic                  time_valid,
    multi_alarm_ctrl_if.slave     wr,
    input  logic                  key_off,
    input  logic                  key_snooze,
    output logic                  beep,
    output logic                  ringing,
    output logic [IDX_W-1:0]      ring_idx,
    output logic                  chime,
    output logic [NUM_ALARMS-1:0] pending
);

    localparam int RT_W = cnt_width(RING_TIMEOUT_S);
    localparam int CH_W = cnt_width(CHIME_S);
    localparam int TD_W = cnt_width(TONE_DIV - 1);
    localparam logic [RT_W-1:0] RT_LAST  = RT_W'(RING_TIMEOUT_S - 1);
    localparam logic [CH_W-1:0] CH_LOAD  = CH_W'(CHIME_S);
    localparam logic [TD_W-1:0] TD_LAST  = TD_W'(TONE_DIV - 1);

    logic [NUM_ALARMS-1:0] trig_vec;
    logic [NUM_ALARMS-1:0] ring_vec;
    logic [NUM_ALARMS-1:0] grant_vec;
    logic                  arb_found;
    logic                  any_grant;
    logic                  timeout;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ALARMS; gi++) begin : g_ch
            alarm_channel #(
                .SNOOZE_MIN (SNOOZE_MIN)
            ) u_ch (
                .clk        (clk),
                .rst        (rst),
                .sec_tick   (sec_tick),
                .time_valid (time_valid),
                .cur_hour   (cur_hour),
                .cur_min    (cur_min),
                .cur_sec    (cur_sec),
                .wr_sel     (wr.wr_en && (wr.wr_idx == IDX_W'(gi))),
                .wr_hour    (wr.wr_hour),
                .wr_min     (wr.wr_min),
                .wr_enable  (wr.wr_enable),
                .grant      (grant_vec[gi]),
                .key_off    (key_off),
                .key_snooze (key_snooze),
                .timeout    (timeout),
                .trigger    (trig_vec[gi]),
                .is_pending (pending[gi]),
                .is_ringing (ring_vec[gi])
            );
        end
    endgenerate

    assign ringing   = |ring_vec;
    assign any_grant = |grant_vec;

    // Grant only while the ring slot is free, so a hand-over always shows one idle cycle.
    always_comb begin
        grant_vec = '0;
        arb_found = 1'b0;
        ring_idx  = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (!arb_found && pending[i]) begin
                grant_vec[i] = 1'b1;
                arb_found    = 1'b1;
            end
            if (ring_vec[i]) ring_idx = IDX_W'(i);
        end
        if (ringing) grant_vec = '0;
    end

    logic [RT_W-1:0] ring_sec_reg, ring_sec_next;

    assign timeout = ringing & sec_tick & (ring_sec_reg == RT_LAST);

    always_comb begin
        ring_sec_next = ring_sec_reg;
        if (any_grant || timeout) ring_sec_next = '0;
        else if (ringing && sec_tick) ring_sec_next = ring_sec_reg + RT_W'(1);
    end

    logic [CH_W-1:0] chime_cnt_reg, chime_cnt_next;
    logic            chime_trig;

    assign chime_trig = sec_tick & time_valid & (cur_min == '0) & (cur_sec == '0) & ~(|trig_vec);
    assign chime      = (chime_cnt_reg != '0);

    always_comb begin
        chime_cnt_next = chime_cnt_reg;
        if (any_grant) chime_cnt_next = '0;
        else if (chime_trig) chime_cnt_next = CH_LOAD;
        else if (sec_tick && chime) chime_cnt_next = chime_cnt_reg - CH_W'(1);
    end

    logic            active, active_reg, rise;
    logic [TD_W-1:0] tone_cnt_reg, tone_cnt_next, tone_cnt_eff;
    logic            tone_reg, tone_next, tone_eff;

    // The rising cycle is treated as count 0 with the tone low, giving a full first half-period.
    assign active       = ringing | chime;
    assign rise         = active & ~active_reg;
    assign tone_cnt_eff = rise ? '0 : tone_cnt_reg;
    assign tone_eff     = tone_reg & ~rise;
    assign beep         = active & tone_eff;

    always_comb begin
        tone_cnt_next = tone_cnt_eff + TD_W'(1);
        tone_next     = tone_eff;
        if (tone_cnt_eff == TD_LAST) begin
            tone_cnt_next = '0;
            tone_next     = ~tone_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ring_sec_reg  <= '0;
            chime_cnt_reg <= '0;
            active_reg    <= 1'b0;
            tone_cnt_reg  <= '0;
            tone_reg      <= 1'b0;
        end else begin
            ring_sec_reg  <= ring_sec_next;
            chime_cnt_reg <= chime_cnt_next;
            active_reg    <= active;
            tone_cnt_reg  <= tone_cnt_next;
            tone_reg      <= tone_next;
        end
    end

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Directed bench for multi_alarm_ctrl: stimulus queues expectations tagged with a due cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_multi_alarm_ctrl;
    import clock_pkg::*;

    localparam int NA = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst, sec_tick, time_valid, key_off, key_snooze;
    logic [4:0]    cur_hour;
    logic [5:0]    cur_min, cur_sec;
    logic          beep, ringing, chime;
    logic [IW-1:0] ring_idx;
    logic [NA-1:0] pending;

    multi_alarm_ctrl_if #(.IDX_W(IW)) wr ();

    multi_alarm_ctrl #(.NUM_ALARMS(NA)) dut (
        .clk        (clk),
        .rst        (rst),
        .sec_tick   (sec_tick),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
        .time_valid (time_valid),
        .wr         (wr),
        .key_off    (key_off),
        .key_snooze (key_snooze),
        .beep       (beep),
        .ringing    (ringing),
        .ring_idx   (ring_idx),
        .chime      (chime),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        int unsigned   due;
        logic          chk_state;
        logic          rg;
        logic [IW-1:0] idx;
        logic          ch;
        logic [NA-1:0] pd;
        logic          chk_beep;
        logic          bp;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e, fin_e;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;
    int          hh = 0, mm = 0, ss = 0;

    function automatic int unsigned now();
        return cyc + 1;
    endfunction

    task automatic push(input exp_t e);
        int pos;
        pos = q.size();
        while (pos > 0 && q[pos-1].due > e.due) pos--;
        q.insert(pos, e);
    endtask

    task automatic exp_state(input string name, input int unsigned off, input logic rg,
                             input logic [IW-1:0] idx, input logic ch, input logic [NA-1:0] pd);
        exp_t e;
        e.name = name; e.due = now() + off; e.chk_state = 1'b1;
        e.rg = rg; e.idx = idx; e.ch = ch; e.pd = pd;
        e.chk_beep = !(rg || ch); e.bp = 1'b0;
        push(e);
    endtask

    task automatic exp_beep(input string name, input int unsigned off, input logic b);
        exp_t e;
        e.name = name; e.due = now() + off; e.chk_state = 1'b0;
        e.rg = 1'b0; e.idx = '0; e.ch = 1'b0; e.pd = '0;
        e.chk_beep = 1'b1; e.bp = b;
        push(e);
    endtask

    // Monitor: one compare per popped expectation, on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            while (q.size() > 0 && q[0].due <= cyc) begin
                mon_e = q.pop_front();
                n_checks++;
                if ((mon_e.due != cyc) ||
                    (mon_e.chk_state && (ringing !== mon_e.rg || ring_idx !== mon_e.idx ||
                                         chime !== mon_e.ch || pending !== mon_e.pd)) ||
                    (mon_e.chk_beep && beep !== mon_e.bp)) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d due=%0d: got ringing=%0b ring_idx=%0d chime=%0b pending=%b beep=%0b, want ringing=%0b ring_idx=%0d chime=%0b pending=%b beep=%0b",
                             mon_e.name, cyc, mon_e.due, ringing, ring_idx, chime, pending, beep,
                             mon_e.rg, mon_e.idx, mon_e.ch, mon_e.pd, mon_e.bp);
                end else begin
                    $display("check %s cyc=%0d ok", mon_e.name, cyc);
                end
            end
        end
    end

    task automatic nc();
        @(posedge clk);
        #1;
        sec_tick   = 1'b0;
        wr.wr_en   = 1'b0;
        key_off    = 1'b0;
        key_snooze = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) nc();
    endtask

    task automatic drive_time();
        cur_hour = 5'(hh);
        cur_min  = 6'(mm);
        cur_sec  = 6'(ss);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        nc();
        hh = h; mm = m; ss = s;
        drive_time();
    endtask

    task automatic tick();
        ss++;
        if (ss == 60) begin
            ss = 0; mm++;
            if (mm == 60) begin
                mm = 0; hh = (hh + 1) % 24;
            end
        end
        nc();
        drive_time();
        sec_tick = 1'b1;
    endtask

    task automatic prog_alarm(input int idx, input int h, input int m, input logic en);
        nc();
        wr.wr_en     = 1'b1;
        wr.wr_idx    = IW'(idx);
        wr.wr_hour   = 5'(h);
        wr.wr_min    = 6'(m);
        wr.wr_enable = en;
    endtask

    task automatic press(input logic off, input logic snz);
        nc();
        key_off    = off;
        key_snooze = snz;
    endtask

    task automatic clear_all();
        for (int i = 0; i < NA; i++) prog_alarm(i, 0, 0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, want < 1000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sec_tick = 1'b0; time_valid = 1'b1; key_off = 1'b0; key_snooze = 1'b0;
        cur_hour = '0; cur_min = '0; cur_sec = '0;
        wr.wr_en = 1'b0; wr.wr_idx = '0; wr.wr_hour = '0; wr.wr_min = '0; wr.wr_enable = 1'b0;
        idle(3);
        n_checks++;
        if (ringing !== 1'b0) begin
            n_err++;
            $display("FAIL in_reset_ringing: got %0b, want 0", ringing);
        end else $display("check in_reset_ringing ok");
        n_checks++;
        if (chime !== 1'b0) begin
            n_err++;
            $display("FAIL in_reset_chime: got %0b, want 0", chime);
        end else $display("check in_reset_chime ok");
        n_checks++;
        if (pending !== 4'b0000) begin
            n_err++;
            $display("FAIL in_reset_pending: got %b, want 0000", pending);
        end else $display("check in_reset_pending ok");
        n_checks++;
        if (beep !== 1'b0) begin
            n_err++;
            $display("FAIL in_reset_beep: got %0b, want 0", beep);
        end else $display("check in_reset_beep ok");
        nc();
        rst = 1'b0;
        exp_state("reset", 0, 1'b0, 2'd0, 1'b0, 4'b0000);

        // Alarm 2 at 07:30, beep period, dismiss
        set_time(7, 29, 59);
        prog_alarm(2, 7, 30, 1'b1);
        tick();
        exp_state("t1_pending", 1, 1'b0, 2'd0, 1'b0, 4'b0100);
        exp_state("t1_ring", 2, 1'b1, 2'd2, 1'b0, 4'b0000);
        exp_beep("t1_beep_rise", 2, 1'b0);
        exp_beep("t1_beep_lo_end", 2 + 12499, 1'b0);
        exp_beep("t1_beep_hi", 2 + 12500, 1'b1);
        exp_beep("t1_beep_hi_end", 2 + 24999, 1'b1);
        exp_beep("t1_beep_lo2", 2 + 25000, 1'b0);
        idle(25010);
        press(1'b1, 1'b0);
        exp_state("t1_off", 1, 1'b0, 2'd0, 1'b0, 4'b0000);

        // Alarms 0 and 3 at 06:00: priority and chime suppression
        prog_alarm(0, 6, 0, 1'b1);
        prog_alarm(3, 6, 0, 1'b1);
        set_time(5, 59, 59);
        tick();
        exp_state("t2_pending", 1, 1'b0, 2'd0, 1'b0, 4'b1001);
        exp_state("t2_ring0", 2, 1'b1, 2'd0, 1'b0, 4'b1000);
        idle(2);
        press(1'b1, 1'b0);
        exp_state("t2_gap", 1, 1'b0, 2'd0, 1'b0, 4'b1000);
        exp_state("t2_ring3", 2, 1'b1, 2'd3, 1'b0, 4'b0000);
        idle(2);
        press(1'b1, 1'b0);
        exp_state("t2_off3", 1, 1'b0, 2'd0, 1'b0, 4'b0000);

        // Snooze on alarm 1, re-ring after 300 ticks, off+snooze together
        clear_all();
        prog_alarm(1, 10, 15, 1'b1);
        set_time(10, 14, 59);
        tick();
        exp_state("t3_ring", 2, 1'b1, 2'd1, 1'b0, 4'b0000);
        idle(2);
        press(1'b0, 1'b1);
        exp_state("t3_snoozed", 1, 1'b0, 2'd0, 1'b0, 4'b0000);
        repeat (299) tick();
        exp_state("t3_snz299", 1, 1'b0, 2'd0, 1'b0, 4'b0000);
        tick();
        exp_state("t3_pend", 1, 1'b0, 2'd0, 1'b0, 4'b0010);
        exp_state("t3_rering", 2, 1'b1, 2'd1, 1'b0, 4'b0000);
        idle(2);
        press(1'b1, 1'b1);
        exp_state("t3_off_wins", 1, 1'b0, 2'd0, 1'b0, 4'b0000);
        repeat (300) tick();
        exp_state("t3_stays_idle", 1, 1'b0, 2'd0, 1'b0, 4'b0000);
        exp_state("t3_stays_idle2", 2, 1'b0, 2'd0, 1'b0, 4'b0000);

        // Ring timeout
        prog_alarm(1, 11, 30, 1'b1);
        set_time(11, 29, 59);
        tick();
        exp_state("t4_ring", 2, 1'b1, 2'd1, 1'b0, 4'b0000);
        idle(2);
        repeat (59) tick();
        exp_state("t4_59", 1, 1'b1, 2'd1, 1'b0, 4'b0000);
        tick();
        exp_state("t4_timeout", 1, 1'b0, 2'd0, 1'b0, 4'b0000);
        repeat (5) tick();
        exp_state("t4_no_retrig", 1, 1'b0, 2'd0, 1'b0, 4'b0000);

        // Hourly chime, then suppressed by time_valid=0
        clear_all();
        set_time(8, 59, 59);
        tick();
        exp_state("t5_chime", 1, 1'b0, 2'd0, 1'b1, 4'b0000);
        exp_beep("t5_beep_rise", 1, 1'b0);
        idle(3);
        exp_state("t5_chime_hold", 0, 1'b0, 2'd0, 1'b1, 4'b0000);
        tick();
        exp_state("t5_chime_end", 1, 1'b0, 2'd0, 1'b0, 4'b0000);
        set_time(9, 59, 59);
        time_valid = 1'b0;
        tick();
        exp_state("t5_tv0", 1, 1'b0, 2'd0, 1'b0, 4'b0000);
        exp_state("t5_tv0b", 2, 1'b0, 2'd0, 1'b0, 4'b0000);
        nc();
        time_valid = 1'b1;

        // Rewrite a ringing alarm, then reset in the middle of a snooze
        prog_alarm(2, 14, 12, 1'b1);
        set_time(14, 11, 59);
        tick();
        exp_state("t6_ring", 2, 1'b1, 2'd2, 1'b0, 4'b0000);
        idle(2);
        prog_alarm(2, 14, 14, 1'b1);
        exp_state("t6_rewrite", 1, 1'b0, 2'd0, 1'b0, 4'b0000);
        set_time(14, 13, 59);
        tick();
        exp_state("t6_ring2", 2, 1'b1, 2'd2, 1'b0, 4'b0000);
        idle(2);
        press(1'b0, 1'b1);
        repeat (10) tick();
        nc();
        rst = 1'b1;
        exp_state("t6_reset", 1, 1'b0, 2'd0, 1'b0, 4'b0000);
        nc();
        rst = 1'b0;
        repeat (300) tick();
        exp_state("t6_post_reset", 1, 1'b0, 2'd0, 1'b0, 4'b0000);

        // Programming the current time does not fire retroactively
        set_time(15, 20, 0);
        prog_alarm(0, 15, 20, 1'b1);
        idle(2);
        exp_state("t7_no_retro", 0, 1'b0, 2'd0, 1'b0, 4'b0000);
        tick();
        exp_state("t7_next_tick", 1, 1'b0, 2'd0, 1'b0, 4'b0000);

        idle(5);
        n_checks++;
        if (ringing !== 1'b0) begin
            n_err++;
            $display("FAIL end_ringing: got %0b, want 0", ringing);
        end else $display("check end_ringing ok");
        n_checks++;
        if (chime !== 1'b0) begin
            n_err++;
            $display("FAIL end_chime: got %0b, want 0", chime);
        end else $display("check end_chime ok");
        n_checks++;
        if (pending !== 4'b0000) begin
            n_err++;
            $display("FAIL end_pending: got %b, want 0000", pending);
        end else $display("check end_pending ok");
        n_checks++;
        if (beep !== 1'b0) begin
            n_err++;
            $display("FAIL end_beep: got %0b, want 0", beep);
        end else $display("check end_beep ok");
        while (q.size() > 0) begin
            fin_e = q.pop_front();
            n_checks++;
            n_err++;
            $display("FAIL %s: never compared, got no sample at cyc %0d, want sample by cyc %0d",
                     fin_e.name, cyc, fin_e.due);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
